// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and helper functions for the AES key-expansion datapath.
//   SBOX      : forward AES S-box, indexed by the input byte
//   RCON_INIT : first round constant of an expansion
//   AES_NRK   : number of round keys held in the round key register file
//   KRF_AW    : round key register file address width
//   xtime     : multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   rot_word  : cyclic left rotation of a word by one byte
//   sub_word  : S-box substitution of each byte of a word
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam int         AES_NRK   = 11;
    localparam int         KRF_AW    = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_keyexp_round.sv
// ---------------------------------------------------------------------------
// aes_keyexp_round
// Purely combinational AES-128 next-round-key generator.
// Ports:
//   rkreg   [127:0] in  : current round key, w0 = [127:96], w3 = [31:0]
//   rcon    [7:0]   in  : round constant applied to this step
//   nextkey [127:0] out : following round key
// ---------------------------------------------------------------------------
module aes_keyexp_round
    import aes_pkg::*;
(
    input  logic [127:0] rkreg,
    input  logic [7:0]   rcon,
    output logic [127:0] nextkey
);

    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;

    assign t  = sub_word(rot_word(rkreg[31:0])) ^ {rcon, 24'h0};

    // Each new word chains off the one just produced, so this is a
    // ripple of XORs rather than four independent terms.
    assign n0 = rkreg[127:96] ^ t;
    assign n1 = rkreg[95:64]  ^ n0;
    assign n2 = rkreg[63:32]  ^ n1;
    assign n3 = rkreg[31:0]   ^ n2;

    assign nextkey = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_keyexp_datapath.sv
// ---------------------------------------------------------------------------
// aes_keyexp_datapath
// Round-key datapath for AES-128: expands the cipher key into ten round keys,
// holds all eleven in a round key register file (KRF) and serves registered
// read data to the AddRoundKey path.
// Ports:
//   clk      in         : system clock, rising edge
//   rst      in         : synchronous reset, active-high
//   ckey     in  [KW]   : cipher key, w0 = [127:96]
//   keysel   in         : 0 selects ckey, 1 selects the expanded next key
//   rndkren  in         : round-key register load enable
//   wrrndkrf in         : KRF write enable
//   krfaddr  in  [4]    : KRF write and read address (11..15 are unmapped)
//   rconen   in         : advance the round constant after use
//   rdkey    out [KW]   : registered KRF read data (one cycle latency)
//   keyvalid out        : all eleven round keys written since last key load
// Build option:
//   AES_KRF_ZEROIZE_EN : rst also clears every KRF entry to 0. Without it
//                        the KRF has no reset and contents survive rst.
// ---------------------------------------------------------------------------
module aes_keyexp_datapath
    import aes_pkg::*;
#(
    parameter int NRK = AES_NRK,
    parameter int KW  = 128
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [KW-1:0]     ckey,
    input  logic              keysel,
    input  logic              rndkren,
    input  logic              wrrndkrf,
    input  logic [KRF_AW-1:0] krfaddr,
    input  logic              rconen,
    output logic [KW-1:0]     rdkey,
    output logic              keyvalid
);

    logic [KW-1:0] rkreg;
    logic [7:0]    rcon;
    logic [KW-1:0] nextkey;
    logic [KW-1:0] wdata;
    logic          addr_ok;
    logic          krf_we;

    logic [KW-1:0] krf [NRK];

    aes_keyexp_round u_round (
        .rkreg   (rkreg),
        .rcon    (rcon),
        .nextkey (nextkey)
    );

    assign wdata   = keysel ? nextkey : ckey;
    assign addr_ok = int'(krfaddr) < NRK;
    assign krf_we  = wrrndkrf && addr_ok;

    // Round-key register, round constant, read register and keyvalid.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is what makes the KRF read return the
    // old contents when the same address is written in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rkreg    <= '0;
            rcon     <= RCON_INIT;
            rdkey    <= '0;
            keyvalid <= 1'b0;
        end else begin
            if (rndkren) begin
                rkreg <= wdata;
                // A fresh key load restarts the constant sequence and wins
                // over an advance request in the same cycle.
                if (!keysel) begin
                    rcon <= RCON_INIT;
                end else if (rconen) begin
                    rcon <= xtime(rcon);
                end
            end

            rdkey <= addr_ok ? krf[krfaddr] : '0;

            if (krf_we) begin
                if (krfaddr == '0) begin
                    keyvalid <= 1'b0;
                end else if (krfaddr == KRF_AW'(NRK - 1)) begin
                    keyvalid <= 1'b1;
                end
            end
        end
    end

`ifdef AES_KRF_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NRK; i++) begin
                krf[i] <= '0;
            end
        end else if (krf_we) begin
            krf[krfaddr] <= wdata;
        end
    end
`else
    // NOTE: the key array deliberately has no reset so it can map onto
    // RAM/LUT storage; a reset term would force it into discrete flops.
    always_ff @(posedge clk) begin
        if (krf_we) begin
            krf[krfaddr] <= wdata;
        end
    end
`endif

endmodule

// File: tb/tb_aes_keyexp_datapath.sv
// ---------------------------------------------------------------------------
// tb_aes_keyexp_datapath
// Self-checking bench for aes_keyexp_datapath: a FIPS-197 vector table, hand
// sequences for read-before-write, unmapped addresses and mid-expansion reset,
// then random control traffic against a word-level key schedule model whose
// S-box is derived from GF(2^8) inversion plus the affine map.
// Honours AES_KRF_ZEROIZE_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_aes_keyexp_datapath;

    logic         clk;
    logic         rst;
    logic [127:0] ckey;
    logic         keysel;
    logic         rndkren;
    logic         wrrndkrf;
    logic [3:0]   krfaddr;
    logic         rconen;
    logic [127:0] rdkey;
    logic         keyvalid;

    aes_keyexp_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .ckey     (ckey),
        .keysel   (keysel),
        .rndkren  (rndkren),
        .wrrndkrf (wrrndkrf),
        .krfaddr  (krfaddr),
        .rconen   (rconen),
        .rdkey    (rdkey),
        .keyvalid (keyvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] tb_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // One AES-128 key schedule step written in the w[i] = w[i-4] ^ temp form.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [8];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 8; i++) begin
            temp = w[i-1];
            if (i == 4) begin
                temp = {temp[23:0], temp[31:24]};
                for (int b = 0; b < 4; b++) temp[8*b +: 8] = tb_sbox[temp[8*b +: 8]];
                temp = temp ^ {rc, 24'h0};
            end
            w[i] = w[i-4] ^ temp;
        end
        return {w[4], w[5], w[6], w[7]};
    endfunction

    logic [127:0] m_rk;
    logic [7:0]   m_rcon;
    logic [127:0] m_rd;
    logic         m_rd_known;
    logic         m_kv;
    logic [127:0] m_krf   [16];
    logic         m_known [16];

    initial begin
        for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
        m_rd_known = 1'b0;
    end

    // Drive one cycle of controls, advance the model, sample #1 after the edge.
    task automatic cycle(input logic r, input logic [127:0] k, input logic ks,
                         input logic rke, input logic wr, input logic [3:0] a,
                         input logic rce);
        logic [127:0] wd;
        rst = r; ckey = k; keysel = ks; rndkren = rke;
        wrrndkrf = wr; krfaddr = a; rconen = rce;
        wd = ks ? key_step(m_rk, m_rcon) : k;
        if (r) begin
            m_rk = '0; m_rcon = 8'h01; m_rd = '0; m_rd_known = 1'b1; m_kv = 1'b0;
            for (int i = 0; i < 16; i++) begin
`ifdef AES_KRF_ZEROIZE_EN
                m_krf[i] = '0; m_known[i] = (i < 11);
`else
                m_known[i] = 1'b0;
`endif
            end
        end else begin
            if (a <= 4'd10) begin
                m_rd = m_krf[a]; m_rd_known = m_known[a];
            end else begin
                m_rd = '0; m_rd_known = 1'b1;
            end
            if (wr && a <= 4'd10) begin
                m_krf[a] = wd; m_known[a] = 1'b1;
                if (a == 4'd0) m_kv = 1'b0;
                else if (a == 4'd10) m_kv = 1'b1;
            end
            if (rke) begin
                m_rk = wd;
                if (!ks) m_rcon = 8'h01;
                else if (rce) m_rcon = gmul(m_rcon, 8'h02);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expand(input logic [127:0] k);
        cycle(1'b0, k, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        for (int a = 1; a <= 10; a++) cycle(1'b0, k, 1'b1, 1'b1, 1'b1, 4'(a), 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic [127:0] ckey;
        logic         keysel;
        logic         rndkren;
        logic         wrrndkrf;
        logic [3:0]   addr;
        logic         rconen;
        logic         chk_rcon;
        logic [7:0]   exp_rcon;
        logic         chk_rd;
        logic [127:0] exp_rd;
        logic         exp_kv;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic ks, input logic rke,
                                input logic wr, input logic [3:0] a, input logic rce,
                                input logic cr, input logic [7:0] er,
                                input logic cd, input logic [127:0] ed, input logic kv);
        vec_t v;
        v.rst = r; v.ckey = FIPS_KEY; v.keysel = ks; v.rndkren = rke;
        v.wrrndkrf = wr; v.addr = a; v.rconen = rce;
        v.chk_rcon = cr; v.exp_rcon = er; v.chk_rd = cd; v.exp_rd = ed; v.exp_kv = kv;
        return v;
    endfunction

    logic [7:0] rc_list [10];

    initial begin
        logic [127:0] newkey;
        logic [127:0] oldval;
        logic [127:0] rk;
        vec_t v;

        rst = 1'b1; ckey = '0; keysel = 1'b0; rndkren = 1'b0;
        wrrndkrf = 1'b0; krfaddr = '0; rconen = 1'b0;
        build_sbox();

        rc_list = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        tbl.push_back(mk(1, 0, 0, 0, 4'd0, 0, 0, 8'h00, 1, '0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4'd0, 0, 1, 8'h01, 0, '0, 0));
        for (int a = 1; a <= 10; a++)
            tbl.push_back(mk(0, 1, 1, 1, 4'(a), 1, 1, rc_list[a-1], 0, '0, a == 10));
        tbl.push_back(mk(0, 0, 0, 0, 4'd1,  0, 0, 8'h00, 1, FIPS_R1,  1));
        tbl.push_back(mk(0, 0, 0, 0, 4'd10, 0, 0, 8'h00, 1, FIPS_R10, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'd0,  0, 0, 8'h00, 1, FIPS_KEY, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'd12, 0, 0, 8'h00, 1, '0,       1));
        tbl.push_back(mk(0, 0, 0, 0, 4'd15, 0, 0, 8'h00, 1, '0,       1));
        // Second load: rcon has advanced past 36 to 6c, load restores 01.
        tbl.push_back(mk(0, 0, 1, 1, 4'd0,  0, 1, 8'h6c, 0, '0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'd0,  0, 1, 8'h01, 1, FIPS_KEY, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.chk_rcon) check($sformatf("tbl%0d rcon", i), 128'(dut.rcon), 128'(v.exp_rcon));
            cycle(v.rst, v.ckey, v.keysel, v.rndkren, v.wrrndkrf, v.addr, v.rconen);
            if (v.chk_rd) check($sformatf("tbl%0d rdkey", i), rdkey, v.exp_rd);
            check($sformatf("tbl%0d keyvalid", i), 128'(keyvalid), 128'(v.exp_kv));
        end

        // Read-before-write on address 5.
        newkey = {$urandom, $urandom, $urandom, $urandom};
        oldval = key_step(key_step(key_step(key_step(key_step(FIPS_KEY, 8'h01), 8'h02), 8'h04), 8'h08), 8'h10);
        cycle(1'b0, newkey, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        check("rbw old", rdkey, oldval);
        cycle(1'b0, newkey, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
        check("rbw new", rdkey, newkey);

        // Write to an unmapped address leaves every entry intact.
        cycle(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0);
        check("oor wr rd", rdkey, '0);
        for (int a = 0; a <= 10; a++) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'(a), 1'b0);
            check($sformatf("oor keep %0d", a), rdkey, m_krf[a]);
        end

        // Reset asserted when the expansion reaches address 4.
        cycle(1'b0, FIPS_KEY, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        for (int a = 1; a <= 3; a++) cycle(1'b0, FIPS_KEY, 1'b1, 1'b1, 1'b1, 4'(a), 1'b1);
        cycle(1'b1, FIPS_KEY, 1'b1, 1'b1, 1'b0, 4'd4, 1'b1);
        check("mid rst rcon", 128'(dut.rcon), 128'h01);
        check("mid rst keyvalid", 128'(keyvalid), '0);
        check("mid rst rdkey", rdkey, '0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
`ifdef AES_KRF_ZEROIZE_EN
        check("zeroize addr0", rdkey, '0);
`endif
        expand(FIPS_KEY);
        check("reexp keyvalid", 128'(keyvalid), 128'h1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0);
        check("reexp r10", rdkey, FIPS_R10);

        // Random traffic against the model.
        expand({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 400; i++) begin
            logic ks;
            ks = 1'($urandom_range(0, 3) != 0);
            cycle(1'b0, {$urandom, $urandom, $urandom, $urandom}, ks,
                  1'($urandom), 1'($urandom), 4'($urandom), ks & 1'($urandom));
            if (m_rd_known) check($sformatf("rnd%0d rdkey", i), rdkey, m_rd);
            check($sformatf("rnd%0d keyvalid", i), 128'(keyvalid), 128'(m_kv));
            check($sformatf("rnd%0d rcon", i), 128'(dut.rcon), 128'(m_rcon));
            check($sformatf("rnd%0d rkreg", i), dut.rkreg, m_rk);
        end

        rk = key_step(FIPS_KEY, 8'h01);
        if (rk !== FIPS_R1) $display("model disagrees with FIPS-197 round 1 key");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/aes_keyexp_datapath.md
Name: aes_keyexp_datapath

Overview:
Round-key datapath driven by the AES control unit's key-expansion FSM.
- Takes the 128-bit cipher key and generates the ten expanded round keys using the rcon generator and a byte S-box.
- Stores all eleven round keys (addresses 0..10) in a round key register file (KRF).
- Serves registered read data to the encryption/decryption AddRoundKey path, addressed by krfaddr.

Parameters:
NRK, 11, number of round keys held in the KRF (addresses 0..NRK-1).
KW, 128, key/round-key width in bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
ckey  input  128  cipher key; w0 = [127:96], w3 = [31:0]
keysel  input  1  0: source is ckey; 1: source is expanded next key
rndkren  input  1  round-key register load enable
wrrndkrf  input  1  KRF write enable
krfaddr  input  4  KRF write address and read address
rconen  input  1  advance the rcon generator after use
rdkey  output  128  registered KRF read data
keyvalid  output  1  all eleven round keys written since the last key load

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: rkreg = 0, rcon = 8'h01, rdkey = 0, keyvalid = 0.
- Next-key function, combinational from rkreg:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- Write-data mux: wdata = keysel ? nextkey : ckey.
- rkreg update: when rndkren = 1, rkreg <= wdata on the rising edge; otherwise it holds.
- KRF write: when wrrndkrf = 1 and krfaddr <= 10, krf[krfaddr] <= wdata. Writes to addresses 11..15 are ignored.
- rcon generator:
  - rndkren = 1 and keysel = 0: rcon <= 8'h01.
  - rndkren = 1 and rconen = 1: rcon <= xtime(rcon), i.e. shift left by one; if bit7 was set, XOR with 8'h1b.
  - Sequence of values used: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Expected control sequence (one cycle each):
  - Cycle 1: keysel = 0, address 0 → writes ckey.
  - Cycles 2..11: keysel = 1, rconen = 1, addresses 1..10 → writes round keys 1..10.
- Read path:
  - Every cycle rdkey <= (krfaddr <= 10) ? krf[krfaddr] : 0. Latency is one cycle.
  - Read on the same cycle as a write to the same address returns the old contents (read-before-write).
- keyvalid:
  - Cleared when a write lands on address 0.
  - Set when a write lands on address 10.
  - Otherwise holds.
- rst asserted mid-expansion: rkreg, rcon, rdkey and keyvalid reset. KRF contents are undefined unless the optional feature is compiled in. A later expansion must restart from address 0.
- rndkren = 0 with wrrndkrf = 1: the KRF still writes wdata, computed from the held rkreg. The control unit never issues this combination, but the behaviour is defined as stated.

Optional Feature:
AES_KRF_ZEROIZE_EN
- Defined: rst also clears all eleven KRF entries to 0, so a read after reset returns 0.
- Undefined: KRF entries have no reset, which allows RAM/LUT inference; contents persist across rst.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry S-box constant table;
  - the xtime and SubWord/RotWord functions;
  - RCON_INIT = 8'h01;
  - NRK and KRF address width constants.
- One sub-module: aes_keyexp_round, a purely combinational next-key generator taking rkreg and rcon and producing nextkey. The KRF, registers and rcon generator live in the top module.

Test Plan:
- FIPS-197 key expansion:
  - Stimulus: rst, then ckey = 2b7e151628aed2a6abf7158809cf4f3c and the 11-cycle control sequence.
  - Required: read addr 1 → rdkey = a0fafe1788542cb123a339392a6c7605 one cycle later.
  - Required: read addr 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: keyvalid = 1 after the addr-10 write.
- rcon walk: during the expansion, rcon at each of addresses 1..10 equals 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Required: a second keysel = 0 load restores rcon = 01 and clears keyvalid.
- Read-before-write: write addr 5 with new data while reading addr 5 → rdkey shows the old value; the following read shows the new value.
- Out-of-range addresses: write to address 12 → no KRF entry changes; read of address 12 or 15 → rdkey = 0.
- Reset mid-expansion: assert rst at address 4 → rcon = 01, keyvalid = 0, rdkey = 0.
  - With AES_KRF_ZEROIZE_EN defined: reading address 0 returns 0.
  - Then a full re-expansion reproduces the FIPS-197 round-10 key.
